// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, flush and error pulses.
// Optional first-word-fall-through read path: define FIFO_FWFT_EN.
module fifo_flagged #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   wr_en,
    output logic                   full_flag,
    output logic                   almost_full,
    output logic                   overflow,
    output logic [WIDTH-1:0]       rdata,
    input  logic                   rd_en,
    output logic                   empty_flag,
    output logic                   almost_empty,
    output logic                   underflow,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_size
        $error("fifo_flagged: WIDTH must be >=1 and DEPTH a power of two >=2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_flagged: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flagged: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          af_q, af_d, ae_q, ae_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          wr_acc, rd_acc;

    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    // Count is the pointer distance; the extra pointer MSB makes DEPTH distinct from 0.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + CW'(1);
            if (rd_acc) rptr_d = rptr_q + CW'(1);
            ovf_d = wr_en & full_q;
            udf_d = rd_en & empty_q;
        end
        count_d = wptr_d - rptr_d;
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_THRESH));
        ae_d    = (count_d <= CW'(AE_THRESH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) mem[wptr_q[AW-1:0]] <= wdata;
    end

`ifdef FIFO_FWFT_EN
    assign rdata = empty_q ? '0 : mem[rptr_q[AW-1:0]];
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (clr)         rdata_d = '0;
        else if (rd_acc) rdata_d = mem[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
`endif

    assign full_flag    = full_q;
    assign empty_flag   = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign count        = count_q;

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
Parametrised successor to the basic single-clock FIFO. Keeps the same write/read/full/empty interface, so existing instantiations port over unchanged. Adds:
- programmable almost-full and almost-empty thresholds
- a live occupancy count
- synchronous flush
- overflow and underflow error pulses
- optional first-word-fall-through read mode

It sits between producer and consumer blocks on the datapath as the general-purpose buffer.

Parameters:
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush, active-high
- wdata  in  WIDTH  write data
- wr_en  in  1  write request
- full_flag  out  1  FIFO holds DEPTH entries
- almost_full  out  1  count >= AF_THRESH
- overflow  out  1  one-cycle pulse: write rejected
- rdata  out  WIDTH  read data
- rd_en  in  1  read request
- empty_flag  out  1  FIFO holds 0 entries
- almost_empty  out  1  count <= AE_THRESH
- underflow  out  1  one-cycle pulse: read rejected
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst low, async):
  - Pointers and count = 0.
  - empty_flag=1, almost_empty=1.
  - full_flag=0, almost_full=0 (AF_THRESH>=1).
  - overflow=0, underflow=0, rdata=0.
  - Memory contents are not reset.
- Storage and pointers:
  - DEPTH x WIDTH register array.
  - Read and write pointers are $clog2(DEPTH)+1 bits; the extra MSB disambiguates full from empty.
  - Address wraps modulo DEPTH.
- Accept rules, evaluated on the rising edge:
  - wr_acc = wr_en & ~full_flag
  - rd_acc = rd_en & ~empty_flag
  - Flags are the registered pre-edge values.
- Write: on wr_acc, mem[wptr] <= wdata; wptr increments.
- Read, standard mode:
  - On rd_acc, rdata <= mem[rptr]; rptr increments.
  - Data is valid on rdata the cycle after rd_en is accepted (1-cycle latency).
  - rdata holds its value when no read is accepted.
- Count update:
  - wr_acc only: +1
  - rd_acc only: -1
  - both accepted: unchanged
  - neither: unchanged
- Flags:
  - full_flag = (count==DEPTH)
  - empty_flag = (count==0)
  - almost_full and almost_empty use the thresholds above.
  - All flags are registered, derived from the next-state count, and update in the same edge as count.
- Simultaneous read and write:
  - When full: read accepted, write rejected (overflow=1); count becomes DEPTH-1.
  - When empty: write accepted, read rejected (underflow=1); count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- Error pulses:
  - overflow <= wr_en & full_flag
  - underflow <= rd_en & empty_flag
  - Each is high for exactly one cycle per rejected request.
  - Neither is sticky.
  - Rejected operations change no state.
- Flush (clr=1):
  - Next edge: pointers and count = 0; flags return to reset values; rdata=0.
  - clr has priority over wr_en and rd_en in the same cycle; those requests are dropped without error pulses.
- Reset mid-operation: state collapses immediately to reset values; pending data is lost.
- Threshold range:
  - Parameters outside their legal ranges are a configuration error.
  - Flagged by an elaboration-time $error.

Optional Feature:
- Macro: FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - rdata presents mem[rptr] combinationally whenever empty_flag=0.
  - rd_en acts as a pop/acknowledge of the currently displayed word.
  - Data is visible with zero read latency.
  - rdata is 0 while empty.
  - Accept rules, count and flags are unchanged.
- Undefined: standard registered read with 1-cycle latency, as described above.

Test Plan:
All scenarios use WIDTH=32, DEPTH=8, AF_THRESH=6, AE_THRESH=2.
1. Reset release, then write 0xD4F40099, 0x281B86C4 alternately for 8 cycles -> count steps 1..8; almost_empty drops at count=3; almost_full rises at count=6; full_flag=1 at 8.
2. While full, wr_en=1 with 0xBABABABA for 1 cycle -> overflow pulses once, count stays 8, word is not stored; subsequent 8 reads return the original 8 words in order.
3. While empty, rd_en=1 for 1 cycle -> underflow pulses once, rdata unchanged, count stays 0.
4. At count=4, wr_en=1 and rd_en=1 together for 3 cycles -> count stays 4; reads return the oldest words in order; no error pulses.
5. Write 0x76543210 and 0xFFFFFFFF, then clr=1 together with wr_en=1 (0x89ABCDEF) -> count=0, empty_flag=1, no overflow; a following rd_en gives an underflow pulse.
6. Assert rst low mid-burst at count=5 -> outputs reach reset values immediately (before the next clock edge). With FIFO_FWFT_EN, one write of 0x12345678 -> rdata=0x12345678 before any rd_en; rd_en pops it and empty_flag=1.
